// File: rtl/serial_bus_cfg_pkg.sv
// rtl/serial_bus_cfg_pkg.sv - shared state codes and defaults for the front-panel command entry
package serial_bus_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEL_MASTER = 3'd1,
    SEL_SLAVE  = 3'd2,
    SEL_ADDR   = 3'd3,
    SEL_DATA   = 3'd4,
    SEL_BURST  = 3'd5,
    CONFIRM    = 3'd6
  } cfg_state_t;

  localparam int DEF_SLAVE = 1;
  localparam int DEF_BURST = 1;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - W-bit 2-FF synchroniser with rising-edge pulse output
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] pulse
);

  logic [W-1:0] sync1, sync2, prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Pulse is combinational so the consuming logic acts on the third clock.
  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/multi_master_cmd_entry.sv
// rtl/multi_master_cmd_entry.sv - button/switch command entry with per-master valid/ready issue
module multi_master_cmd_entry
  import serial_bus_cfg_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int SLAVE_LEN   = 2,
  parameter int SLAVE_NUM   = 3,
  parameter int ADDR_LEN    = 12,
  parameter int DATA_LEN    = 8,
  parameter int BURST_LEN   = 12,
  parameter int BURST_MAX   = 4095
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             btn_next,
  input  logic                             btn_back,
  input  logic                             btn_up,
  input  logic                             btn_down,
  input  logic [ADDR_LEN-1:0]              switch_array,
  input  logic                             mode_switch,
  input  logic [NUM_MASTERS-1:0]           rw_switch,
  input  logic [NUM_MASTERS-1:0]           go_btn,
  input  logic [NUM_MASTERS-1:0]           cmd_ready,
  output logic [NUM_MASTERS-1:0]           cmd_read,
  output logic [NUM_MASTERS-1:0]           cmd_write,
  output logic [NUM_MASTERS*SLAVE_LEN-1:0] cmd_slave,
  output logic [NUM_MASTERS*ADDR_LEN-1:0]  cmd_addr,
  output logic [NUM_MASTERS*DATA_LEN-1:0]  cmd_data,
  output logic [NUM_MASTERS*BURST_LEN-1:0] cmd_burst,
  output logic [2:0]                       cfg_state,
  output logic                             cfg_busy
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [ADDR_LEN-1:0] BMAX_SW = ADDR_LEN'(BURST_MAX);

  logic [3:0]             btn_pulse;
  logic [NUM_MASTERS-1:0] go_pulse;

  btn_edge #(.W(4)) u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .din   ({btn_next, btn_back, btn_up, btn_down}),
    .pulse (btn_pulse)
  );

  btn_edge #(.W(NUM_MASTERS)) u_go_edge (
    .clk   (clk),
    .reset (reset),
    .din   (go_btn),
    .pulse (go_pulse)
  );

  // Priority resolution: next > back > up > down.
  logic do_next, do_back, do_up, do_down;
  assign do_next = btn_pulse[3];
  assign do_back = btn_pulse[2] & ~do_next;
  assign do_up   = btn_pulse[1] & ~btn_pulse[3] & ~btn_pulse[2];
  assign do_down = btn_pulse[0] & ~(|btn_pulse[3:1]);

  cfg_state_t state, state_nxt;

  logic [MW-1:0]        stg_master;
  logic [SLAVE_LEN-1:0] stg_slave;
  logic [ADDR_LEN-1:0]  stg_addr;
  logic [DATA_LEN-1:0]  stg_data;
  logic [BURST_LEN-1:0] stg_burst;
  logic [BURST_LEN-1:0] burst_cap;
  logic                 commit, clr_stg;

  assign commit  = ~mode_switch & (state == CONFIRM) & do_next;
  assign clr_stg = mode_switch | commit | ((state == SEL_MASTER) & do_back);

  always_comb begin
    if (switch_array == '0)          burst_cap = BURST_LEN'(DEF_BURST);
    else if (switch_array > BMAX_SW) burst_cap = BURST_LEN'(BURST_MAX);
    else                             burst_cap = switch_array[BURST_LEN-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mode_switch) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (do_next | do_up | do_down) state_nxt = SEL_MASTER;
        CONFIRM: if (do_next) state_nxt = IDLE;
                 else if (do_back) state_nxt = SEL_BURST;
        default: if (do_next) state_nxt = cfg_state_t'(state + 3'd1);
                 else if (do_back) state_nxt = cfg_state_t'(state - 3'd1);
      endcase
    end
  end

  always_comb begin
    cfg_state = state;
    cfg_busy  = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_master <= '0;
      stg_slave  <= SLAVE_LEN'(DEF_SLAVE);
      stg_addr   <= '0;
      stg_data   <= '0;
      stg_burst  <= BURST_LEN'(DEF_BURST);
    end else if (clr_stg) begin
      stg_master <= '0;
      stg_slave  <= SLAVE_LEN'(DEF_SLAVE);
      stg_addr   <= '0;
      stg_data   <= '0;
      stg_burst  <= BURST_LEN'(DEF_BURST);
    end else begin
      case (state)
        SEL_MASTER:
          if (do_up)
            stg_master <= (stg_master == MW'(NUM_MASTERS-1)) ? '0 : stg_master + MW'(1);
          else if (do_down)
            stg_master <= (stg_master == '0) ? MW'(NUM_MASTERS-1) : stg_master - MW'(1);
        SEL_SLAVE:
          if (do_up)
            stg_slave <= (stg_slave >= SLAVE_LEN'(SLAVE_NUM)) ? SLAVE_LEN'(1)
                                                               : stg_slave + SLAVE_LEN'(1);
          else if (do_down)
            stg_slave <= (stg_slave <= SLAVE_LEN'(1)) ? SLAVE_LEN'(SLAVE_NUM)
                                                       : stg_slave - SLAVE_LEN'(1);
        SEL_ADDR:  if (do_next) stg_addr  <= switch_array;
        SEL_DATA:  if (do_next) stg_data  <= switch_array[DATA_LEN-1:0];
        SEL_BURST: if (do_next) stg_burst <= burst_cap;
        default: ;
      endcase
    end
  end

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_master
    logic [SLAVE_LEN-1:0] slv_q;
    logic [ADDR_LEN-1:0]  addr_q;
    logic [DATA_LEN-1:0]  data_q;
    logic [BURST_LEN-1:0] burst_q;
    logic                 rd_q, wr_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slv_q   <= SLAVE_LEN'(DEF_SLAVE);
        addr_q  <= '0;
        data_q  <= '0;
        burst_q <= BURST_LEN'(DEF_BURST);
      end else if (commit && stg_master == MW'(m)) begin
        slv_q   <= stg_slave;
        addr_q  <= stg_addr;
        data_q  <= stg_data;
        burst_q <= stg_burst;
      end
    end

    // Pending survives a mode change; only ready retires it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end else if (rd_q | wr_q) begin
        if (cmd_ready[m]) begin
          rd_q <= 1'b0;
          wr_q <= 1'b0;
        end
      end else if (mode_switch && go_pulse[m]) begin
        rd_q <= rw_switch[m];
        wr_q <= ~rw_switch[m];
      end
    end

    assign cmd_read[m]                         = rd_q;
    assign cmd_write[m]                        = wr_q;
    assign cmd_slave[m*SLAVE_LEN +: SLAVE_LEN] = slv_q;
    assign cmd_addr[m*ADDR_LEN +: ADDR_LEN]    = addr_q;
    assign cmd_data[m*DATA_LEN +: DATA_LEN]    = data_q;
    assign cmd_burst[m*BURST_LEN +: BURST_LEN] = burst_q;
  end

endmodule

// File: tb/tb_multi_master_cmd_entry.sv
// tb/tb_multi_master_cmd_entry.sv - directed self-checking bench for multi_master_cmd_entry
module tb_multi_master_cmd_entry;

  localparam logic [3:0] K_NEXT = 4'b1000;
  localparam logic [3:0] K_BACK = 4'b0100;
  localparam logic [3:0] K_UP   = 4'b0010;
  localparam logic [3:0] K_DOWN = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btns = '0;
  logic [11:0] sw = '0;
  logic        mode = 1'b0;
  logic [1:0]  rw = '0;
  logic [1:0]  go = '0;
  logic [1:0]  rdy = '0;
  logic [1:0]  cmd_read, cmd_write;
  logic [3:0]  cmd_slave;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_data;
  logic [23:0] cmd_burst;
  logic [2:0]  cfg_state;
  logic        cfg_busy;

  int total = 0;
  int bad   = 0;
  bit found;

  multi_master_cmd_entry dut (
    .clk          (clk),
    .reset        (reset),
    .btn_next     (btns[3]),
    .btn_back     (btns[2]),
    .btn_up       (btns[1]),
    .btn_down     (btns[0]),
    .switch_array (sw),
    .mode_switch  (mode),
    .rw_switch    (rw),
    .go_btn       (go),
    .cmd_ready    (rdy),
    .cmd_read     (cmd_read),
    .cmd_write    (cmd_write),
    .cmd_slave    (cmd_slave),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_burst    (cmd_burst),
    .cfg_state    (cfg_state),
    .cfg_busy     (cfg_busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_slice(input string tag, input int m, input int s, input int a,
                             input int d, input int b);
    check_val({tag, "_slave"}, 32'(cmd_slave[m*2 +: 2]), s);
    check_val({tag, "_addr"},  32'(cmd_addr[m*12 +: 12]), a);
    check_val({tag, "_data"},  32'(cmd_data[m*8 +: 8]), d);
    check_val({tag, "_burst"}, 32'(cmd_burst[m*12 +: 12]), b);
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    btns = mask;
    repeat (4) @(negedge clk);
    btns = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_state", 32'(cfg_state), 0);
    check_val("rst_busy", 32'(cfg_busy), 0);

    // 1: reset while sitting in CONFIRM
    repeat (6) press(K_NEXT);
    check_val("t1_confirm_state", 32'(cfg_state), 6);
    check_val("t1_confirm_busy", 32'(cfg_busy), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("t1_state", 32'(cfg_state), 0);
    check_val("t1_busy", 32'(cfg_busy), 0);
    check_val("t1_cmd", 32'({cmd_read, cmd_write}), 0);
    check_slice("t1_s0", 0, 1, 0, 0, 1);
    check_slice("t1_s1", 1, 1, 0, 0, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 2: master1, slave3, addr ABC, data 5A, burst 0 -> 1
    press(K_NEXT);
    press(K_UP);
    press(K_NEXT);
    press(K_UP);
    press(K_UP);
    press(K_NEXT);
    sw = 12'hABC; press(K_NEXT);
    sw = 12'hF5A; press(K_NEXT);
    sw = 12'h000; press(K_NEXT);
    check_val("t2_confirm", 32'(cfg_state), 6);
    press(K_NEXT);
    check_val("t2_idle", 32'(cfg_state), 0);
    check_slice("t2_s1", 1, 3, 12'hABC, 8'h5A, 1);
    check_slice("t2_s0", 0, 1, 0, 0, 1);

    // 3: master wrap 1->0, slave wrap 3->1 and 1->3
    press(K_NEXT);
    press(K_UP);
    press(K_UP);
    press(K_NEXT);
    press(K_UP);
    press(K_UP);
    press(K_UP);
    press(K_DOWN);
    press(K_DOWN);
    press(K_NEXT);
    sw = 12'h123; press(K_NEXT);
    sw = 12'h0FF; press(K_NEXT);
    sw = 12'h800; press(K_NEXT);
    press(K_NEXT);
    check_slice("t3_s0", 0, 2, 12'h123, 8'hFF, 12'h800);
    check_slice("t3_s1", 1, 3, 12'hABC, 8'h5A, 1);

    // 5: next+up together, back from SEL_DATA
    press(K_NEXT);
    press(K_NEXT);
    press(K_UP);
    sw = 12'h456; press(K_NEXT | K_UP);
    check_val("t5_next_wins", 32'(cfg_state), 3);
    press(K_NEXT);
    check_val("t5_in_data", 32'(cfg_state), 4);
    press(K_BACK);
    check_val("t5_back", 32'(cfg_state), 3);
    sw = 12'h789; press(K_NEXT);
    sw = 12'h0AA; press(K_NEXT);
    sw = 12'h005; press(K_NEXT);
    press(K_NEXT);
    check_slice("t5_s0", 0, 2, 12'h789, 8'hAA, 5);

    // 6: run mode during SEL_BURST drops staging
    press(K_NEXT);
    press(K_UP);
    press(K_NEXT);
    press(K_UP);
    press(K_NEXT);
    sw = 12'h111; press(K_NEXT);
    sw = 12'h022; press(K_NEXT);
    check_val("t6_in_burst", 32'(cfg_state), 5);
    mode = 1'b1;
    repeat (2) @(negedge clk);
    check_val("t6_state", 32'(cfg_state), 0);
    check_val("t6_busy", 32'(cfg_busy), 0);
    check_slice("t6_keep_s0", 0, 2, 12'h789, 8'hAA, 5);
    check_slice("t6_keep_s1", 1, 3, 12'hABC, 8'h5A, 1);
    mode = 1'b0;
    press(K_NEXT);
    press(K_NEXT);
    press(K_NEXT);
    sw = 12'h222; press(K_NEXT);
    sw = 12'h033; press(K_NEXT);
    sw = 12'h007; press(K_NEXT);
    press(K_NEXT);
    check_slice("t6_s0", 0, 1, 12'h222, 8'h33, 7);
    check_slice("t6_s1", 1, 3, 12'hABC, 8'h5A, 1);

    // 4: run-mode handshake
    mode = 1'b1;
    rw = 2'b10;
    rdy = 2'b00;
    repeat (2) @(negedge clk);
    go = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (cmd_write[0]) found = 1'b1;
    end
    check_val("t4_go0_seen", 32'(found), 1);
    for (int i = 0; i < 5; i++) begin
      check_val("t4_wr0_hold", 32'(cmd_write[0]), 1);
      check_val("t4_rd0_low", 32'(cmd_read[0]), 0);
      if (i == 0) go = 2'b00;
      if (i == 1) begin
        go = 2'b01;
        rw[0] = 1'b1;
      end
      @(negedge clk);
    end
    check_val("t4_wr0_still", 32'(cmd_write[0]), 1);
    rdy[0] = 1'b1;
    @(negedge clk);
    check_val("t4_wr0_drop", 32'(cmd_write[0]), 0);
    rdy[0] = 1'b0;
    repeat (6) @(negedge clk);
    check_val("t4_go0_dropped", 32'({cmd_read[0], cmd_write[0]}), 0);
    go = 2'b00;
    repeat (2) @(negedge clk);

    go = 2'b10;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (cmd_read[1]) found = 1'b1;
    end
    check_val("t4_go1_seen", 32'(found), 1);
    check_val("t4_wr1_low", 32'(cmd_write[1]), 0);
    check_val("t4_m0_idle", 32'({cmd_read[0], cmd_write[0]}), 0);
    rdy[1] = 1'b1;
    @(negedge clk);
    check_val("t4_rd1_drop", 32'(cmd_read[1]), 0);
    rdy[1] = 1'b0;
    go = 2'b00;
    check_slice("t4_keep_s1", 1, 3, 12'hABC, 8'h5A, 1);

    // go ignored in config mode
    mode = 1'b0;
    repeat (2) @(negedge clk);
    go = 2'b11;
    repeat (8) @(negedge clk);
    check_val("t4_cfg_go_ignored", 32'({cmd_read, cmd_write}), 0);
    go = 2'b00;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
